allocator_lsu: RTL and testbench
================================

Name: allocator_lsu

Overview:
- Load/store unit directly downstream of the allocator core.
- Accepts one header-level request at a time (LOCK, UNLOCK, LOAD, INSERT, DELETE).
- Expands each request into a fixed sequence of single-word memory transactions on a valid/ready memory port.
- Returns one response pulse per request, carrying a loaded header where applicable.

Parameters:
- DATA_W, allocator_pkg::DATA_W, width of addresses, sizes and memory data words.
- WORD_BYTES, DATA_W/8, byte offset from a header's size word to its next_addr word.
- LOCK_ADDR, 'h0, byte address of the allocator lock word.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  header_data_req_t  request from core {header_data{addr,size,next_addr}, lsu_op, val}
- lsu_ready_o  out  1  high when a request can be accepted
- rsp_o  out  header_data_rsp_t  response to core {header_data, val}
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  DATA_W  byte address
- mem_wdata_o  out  DATA_W  write data
- mem_rsp_valid_i  in  1  read data valid, or write acknowledge
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset:
  - On rst_i the FSM goes to IDLE immediately; all registers clear.
  - During reset: lsu_ready_o=0, rsp_o='0, mem_req_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-operation abandons the sequence. No memory cleanup; a late mem_rsp_valid_i after reset is ignored in IDLE.
- Memory layout: header at A is size at A and next_addr at A+WORD_BYTES. Header addr is the memory address itself and is not stored.
- Request acceptance:
  - Handshake is req_i.val && lsu_ready_o.
  - lsu_ready_o=1 only in IDLE, so a request is accepted the cycle it arrives in IDLE.
  - req_i fields are registered on acceptance and must not be relied upon afterwards.
- Memory port:
  - At most one outstanding transaction.
  - mem_req_valid_o and its addr, we and wdata are held stable until mem_req_ready_i.
  - The FSM then waits for mem_rsp_valid_i; every transaction, read or write, completes on mem_rsp_valid_i.
  - A response arriving in the same cycle as the handshake is not accepted. The response is sampled only from the cycle after the handshake.
- Beat sequences (A = registered header_data.addr):
  - LOAD:
    - Read A, which gives size.
    - Read A+WORD_BYTES, which gives next_addr.
    - Response header = {addr:A, size, next_addr}.
  - INSERT: write size to A, then write next_addr to A+WORD_BYTES. Response header = request header.
  - DELETE: write next_addr to A+WORD_BYTES; this relinks the predecessor. Response header = request header.
  - LOCK (spin):
    - Read LOCK_ADDR.
    - If rdata != 0, re-issue the read the next cycle, indefinitely.
    - If rdata == 0, write 1 to LOCK_ADDR. Response header = '0.
    - Atomicity relies on this being the sole memory master.
  - UNLOCK: write 0 to LOCK_ADDR. Response header = '0.
  - Undefined lsu_op: no memory traffic; respond the cycle after acceptance with header '0.
- FSM states:
  - IDLE: on accept, go to MEM_REQ with beat=0 (or RESP for an undefined op).
  - MEM_REQ: assert mem_req_valid_o; on mem_req_ready_i go to MEM_WAIT.
  - MEM_WAIT: on mem_rsp_valid_i, capture rdata if a read.
    - If more beats remain: go to MEM_REQ and increment beat.
    - LOCK read with nonzero data: stay on the same beat and go to MEM_REQ.
    - Otherwise: go to RESP.
  - RESP: rsp_o.val=1 for exactly one cycle with header_data valid; go to IDLE.
- Latency with a zero-wait memory (ready always 1, rsp one cycle later):
  - LOAD/INSERT: 5 cycles from accept to rsp val.
  - DELETE/UNLOCK: 3 cycles.
  - LOCK when free: 5 cycles.
- rsp_o.header_data holds its last value after RESP. rsp_o.val is 0 outside RESP.
- Address arithmetic is modulo 2^DATA_W; A+WORD_BYTES wraps silently.

Test Plan:
- Reset asserted in MEM_WAIT of a LOAD -> next cycle lsu_ready_o=0 with all outputs 0; after deassert, IDLE with ready=1; a stale mem_rsp_valid_i is ignored.
- LOAD A='h10, memory['h10]=64, memory['h18]='h100 -> reads 'h10 then 'h18; rsp val one cycle with {addr 'h10, size 64, next 'h100}; zero-wait latency 5.
- INSERT {addr 'h90, size 32, next 'h200} -> writes 'h90=32 then 'h98='h200; one rsp pulse; ready low throughout.
- DELETE {addr 'h10, next 'h90} -> single write 'h18='h90; rsp after 3 cycles; memory['h10] unchanged.
- LOCK with memory[0]=1 for 3 reads then cleared to 0 -> 4 reads, then write 1 to addr 0, then rsp; followed by UNLOCK -> write 0, rsp.
- mem_req_ready_i low for 4 cycles -> addr, we and wdata stable, valid held; req_i.val pulses while busy are ignored.

Source files
------------

// File: rtl/allocator_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : allocator_pkg / allocator_lsu
//  Description : Load/store unit below the allocator core. Expands one
//                header-level request (LOCK, UNLOCK, LOAD, INSERT, DELETE)
//                into single-word valid/ready memory transactions and
//                returns one response pulse per request.
//  Revision    : 1.0 - initial release
// ============================================================================

package allocator_pkg;
    localparam int DATA_W = 64;

    typedef logic [2:0] lsu_op_t;

    // Encodings 0, 6 and 7 are undefined and answered without memory traffic
    localparam lsu_op_t LSU_LOCK   = 3'd1;
    localparam lsu_op_t LSU_UNLOCK = 3'd2;
    localparam lsu_op_t LSU_LOAD   = 3'd3;
    localparam lsu_op_t LSU_INSERT = 3'd4;
    localparam lsu_op_t LSU_DELETE = 3'd5;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        header_data_t header_data;
        lsu_op_t      lsu_op;
        logic         val;
    } header_data_req_t;

    typedef struct packed {
        header_data_t header_data;
        logic         val;
    } header_data_rsp_t;
endpackage

module allocator_lsu
    import allocator_pkg::*;
#(
    parameter int                DATA_W     = allocator_pkg::DATA_W,
    parameter int                WORD_BYTES = DATA_W / 8,
    parameter logic [DATA_W-1:0] LOCK_ADDR  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  header_data_req_t   req_i,
    output logic               lsu_ready_o,
    output header_data_rsp_t   rsp_o,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic               mem_rsp_valid_i,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    localparam logic [DATA_W-1:0] c_word_off = DATA_W'(WORD_BYTES);
    localparam logic [DATA_W-1:0] c_one      = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_REQ  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_beat;
    lsu_op_t           r_op;
    header_data_t      r_hdr;
    logic              r_ready;
    logic              r_mem_valid;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rsp_val;
    header_data_t      r_rsp_hdr;

    lsu_op_t           w_op_sel;
    header_data_t      w_hdr_sel;
    logic              w_beat_sel;
    logic              w_op_valid;
    logic              w_last;
    logic              w_we;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Describe the beat about to be issued: beat 0 of the incoming request
    // while idle, otherwise the beat following the current one. w_last is
    // the index of the final beat of the selected operation.
    always_comb begin
        w_op_sel   = (r_state == S_IDLE) ? req_i.lsu_op      : r_op;
        w_hdr_sel  = (r_state == S_IDLE) ? req_i.header_data : r_hdr;
        w_beat_sel = (r_state == S_IDLE) ? 1'b0 : (r_beat + 1'b1);
        w_op_valid = 1'b1;
        w_last     = 1'b0;
        w_we       = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        case (w_op_sel)
            LSU_LOAD: begin
                w_last = 1'b1;
                w_addr = w_beat_sel ? (w_hdr_sel.addr + c_word_off) : w_hdr_sel.addr;
            end
            LSU_INSERT: begin
                w_last  = 1'b1;
                w_we    = 1'b1;
                w_addr  = w_beat_sel ? (w_hdr_sel.addr + c_word_off) : w_hdr_sel.addr;
                w_wdata = w_beat_sel ? w_hdr_sel.next_addr : w_hdr_sel.size;
            end
            LSU_DELETE: begin
                w_we    = 1'b1;
                w_addr  = w_hdr_sel.addr + c_word_off;
                w_wdata = w_hdr_sel.next_addr;
            end
            LSU_LOCK: begin
                // Beat 0 polls the lock word, beat 1 claims it
                w_last  = 1'b1;
                w_we    = w_beat_sel;
                w_addr  = LOCK_ADDR;
                w_wdata = w_beat_sel ? c_one : '0;
            end
            LSU_UNLOCK: begin
                w_we    = 1'b1;
                w_addr  = LOCK_ADDR;
                w_wdata = '0;
            end
            default: w_op_valid = 1'b0;
        endcase
    end

    // Request sequencing FSM; every output is registered here
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_beat      <= 1'b0;
            r_op        <= '0;
            r_hdr       <= '0;
            r_ready     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_val   <= 1'b0;
            r_rsp_hdr   <= '0;
        end else begin
            r_rsp_val <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (req_i.val && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= req_i.lsu_op;
                        r_hdr   <= req_i.header_data;
                        r_beat  <= 1'b0;
                        if (w_op_valid) begin
                            r_state     <= S_MEM_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= w_we;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_state   <= S_RESP;
                            r_rsp_val <= 1'b1;
                            r_rsp_hdr <= '0;
                        end
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (r_op == LSU_LOAD && !r_beat) begin
                            r_hdr.size <= mem_rdata_i;
                        end
                        if (r_op == LSU_LOCK && !r_beat && (mem_rdata_i != '0)) begin
                            // Lock held elsewhere: repeat the same read
                            r_state     <= S_MEM_REQ;
                            r_mem_valid <= 1'b1;
                        end else if (!r_beat && w_last) begin
                            r_beat      <= 1'b1;
                            r_state     <= S_MEM_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= w_we;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_state   <= S_RESP;
                            r_rsp_val <= 1'b1;
                            case (r_op)
                                LSU_LOAD: begin
                                    r_rsp_hdr.addr      <= r_hdr.addr;
                                    r_rsp_hdr.size      <= r_hdr.size;
                                    r_rsp_hdr.next_addr <= mem_rdata_i;
                                end
                                LSU_INSERT, LSU_DELETE: r_rsp_hdr <= r_hdr;
                                default:                r_rsp_hdr <= '0;
                            endcase
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_ready_o       = r_ready;
    assign rsp_o.header_data = r_rsp_hdr;
    assign rsp_o.val         = r_rsp_val;
    assign mem_req_valid_o   = r_mem_valid;
    assign mem_we_o          = r_mem_we;
    assign mem_addr_o        = r_mem_addr;
    assign mem_wdata_o       = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_allocator_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_allocator_lsu
//  Description : Directed self-checking bench for allocator_lsu with a
//                single-outstanding memory model that answers one cycle
//                after each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_allocator_lsu;
    import allocator_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    header_data_req_t req_i;
    logic             lsu_ready_o;
    header_data_rsp_t rsp_o;
    logic             mem_req_valid_o;
    logic             mem_req_ready_i;
    logic             mem_we_o;
    logic [63:0]      mem_addr_o;
    logic [63:0]      mem_wdata_o;
    logic             mem_rsp_valid_i;
    logic [63:0]      mem_rdata_i;

    always #5 clk_i = ~clk_i;

    allocator_lsu dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .lsu_ready_o     (lsu_ready_o),
        .rsp_o           (rsp_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    // Memory model
    logic        m_rsp_valid = 1'b0;
    logic        inj_rsp     = 1'b0;
    logic        pl_en       = 1'b0;
    logic [63:0] pl_addr     = '0;
    logic [63:0] pl_data     = '0;
    int          lock_rd_cnt = 0;
    int          lock_busy_until = 0;
    logic [63:0] mem [0:31];
    logic [63:0] log_addr  [$];
    logic        log_we    [$];
    logic [63:0] log_wdata [$];

    assign mem_rsp_valid_i = m_rsp_valid | inj_rsp;

    // Accept handshakes, log them, apply writes, respond one cycle later
    always @(posedge clk_i) begin
        m_rsp_valid <= 1'b0;
        if (pl_en) mem[pl_addr[7:3]] <= pl_data;
        if (mem_req_valid_o && mem_req_ready_i) begin
            log_addr.push_back(mem_addr_o);
            log_we.push_back(mem_we_o);
            log_wdata.push_back(mem_wdata_o);
            m_rsp_valid <= 1'b1;
            if (mem_we_o) begin
                mem[mem_addr_o[7:3]] <= mem_wdata_o;
                mem_rdata_i <= '0;
            end else if (mem_addr_o == 64'h0) begin
                lock_rd_cnt <= lock_rd_cnt + 1;
                mem_rdata_i <= (lock_rd_cnt < lock_busy_until) ? 64'd1 : mem[0];
            end else begin
                mem_rdata_i <= mem[mem_addr_o[7:3]];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    // Drive one request for a single cycle while the unit is ready
    task automatic issue(input lsu_op_t op, input logic [63:0] a,
                         input logic [63:0] s, input logic [63:0] n);
        int guard = 0;
        while (!lsu_ready_o && guard < 100) begin
            step();
            guard++;
        end
        req_i.lsu_op                = op;
        req_i.header_data.addr      = a;
        req_i.header_data.size      = s;
        req_i.header_data.next_addr = n;
        req_i.val                   = 1'b1;
        step();
        req_i.val = 1'b0;
    endtask

    // Cycles from acceptance to the response pulse; flags ready seen high
    task automatic wait_rsp(output int lat, output logic rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!rsp_o.val && lat < 300) begin
            if (lsu_ready_o) rdy_seen = 1'b1;
            step();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic rdy;
        int   base;

        rst_i           = 1'b1;
        req_i           = '0;
        mem_req_ready_i = 1'b1;

        preload(64'h10, 64'd64);
        preload(64'h18, 64'h100);
        preload(64'h00, 64'h0);

        chk("rst_ready", lsu_ready_o,     0);
        chk("rst_rsp",   rsp_o,           0);
        chk("rst_valid", mem_req_valid_o, 0);
        chk("rst_we",    mem_we_o,        0);
        chk("rst_addr",  mem_addr_o,      0);
        chk("rst_wdata", mem_wdata_o,     0);
        rst_i = 1'b0;
        step();
        step();
        chk("post_rst_ready", lsu_ready_o, 1);

        // LOAD 'h10
        base = log_addr.size();
        issue(LSU_LOAD, 64'h10, 64'h0, 64'h0);
        wait_rsp(lat, rdy);
        chk("load_latency", lat, 5);
        chk("load_addr",    rsp_o.header_data.addr,      64'h10);
        chk("load_size",    rsp_o.header_data.size,      64'd64);
        chk("load_next",    rsp_o.header_data.next_addr, 64'h100);
        chk("load_nbeats",  log_addr.size() - base, 2);
        chk("load_a0",      log_addr[base],     64'h10);
        chk("load_we0",     log_we[base],       0);
        chk("load_a1",      log_addr[base + 1], 64'h18);
        chk("load_we1",     log_we[base + 1],   0);
        step();
        chk("load_pulse", rsp_o.val, 0);
        chk("load_hold",  rsp_o.header_data.next_addr, 64'h100);

        // INSERT {'h90, 32, 'h200}
        base = log_addr.size();
        issue(LSU_INSERT, 64'h90, 64'd32, 64'h200);
        wait_rsp(lat, rdy);
        chk("ins_latency", lat, 5);
        chk("ins_ready_low", rdy, 0);
        chk("ins_rsp", rsp_o.header_data, {64'h90, 64'd32, 64'h200});
        chk("ins_nbeats", log_addr.size() - base, 2);
        chk("ins_a0", log_addr[base], 64'h90);
        chk("ins_d0", log_wdata[base], 64'd32);
        chk("ins_w0", log_we[base], 1);
        chk("ins_a1", log_addr[base + 1], 64'h98);
        chk("ins_d1", log_wdata[base + 1], 64'h200);
        chk("ins_mem0", mem[5'h12], 64'd32);
        chk("ins_mem1", mem[5'h13], 64'h200);
        step();
        chk("ins_pulse", rsp_o.val, 0);

        // DELETE {'h10, next 'h90}
        base = log_addr.size();
        issue(LSU_DELETE, 64'h10, 64'h0, 64'h90);
        wait_rsp(lat, rdy);
        chk("del_latency", lat, 3);
        chk("del_rsp", rsp_o.header_data, {64'h10, 64'h0, 64'h90});
        chk("del_nbeats", log_addr.size() - base, 1);
        chk("del_a0", log_addr[base], 64'h18);
        chk("del_d0", log_wdata[base], 64'h90);
        chk("del_mem18", mem[5'h03], 64'h90);
        chk("del_mem10", mem[5'h02], 64'd64);

        // LOCK with the lock word busy for three polls
        lock_busy_until = lock_rd_cnt + 3;
        base = log_addr.size();
        issue(LSU_LOCK, 64'hABC, 64'h1, 64'h2);
        wait_rsp(lat, rdy);
        chk("lock_latency", lat, 11);
        chk("lock_rsp", rsp_o.header_data, 0);
        chk("lock_nbeats", log_addr.size() - base, 5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock_rd%0d_we", i),   log_we[base + i],   0);
            chk($sformatf("lock_rd%0d_addr", i), log_addr[base + i], 0);
        end
        chk("lock_wr_we",   log_we[base + 4],    1);
        chk("lock_wr_addr", log_addr[base + 4],  0);
        chk("lock_wr_data", log_wdata[base + 4], 1);
        chk("lock_mem", mem[0], 1);

        // UNLOCK
        base = log_addr.size();
        issue(LSU_UNLOCK, 64'h55, 64'h1, 64'h2);
        wait_rsp(lat, rdy);
        chk("unl_latency", lat, 3);
        chk("unl_rsp", rsp_o.header_data, 0);
        chk("unl_nbeats", log_addr.size() - base, 1);
        chk("unl_wr", {log_we[base], log_addr[base][7:0], log_wdata[base][7:0]}, {1'b1, 8'h0, 8'h0});
        chk("unl_mem", mem[0], 0);

        // Undefined op: immediate response, no memory traffic
        base = log_addr.size();
        issue(3'd7, 64'h33, 64'h44, 64'h55);
        wait_rsp(lat, rdy);
        chk("undef_latency", lat, 1);
        chk("undef_rsp", rsp_o.header_data, 0);
        chk("undef_nbeats", log_addr.size() - base, 0);

        // Stalled memory: request held stable, busy requests ignored
        mem_req_ready_i = 1'b0;
        base = log_addr.size();
        issue(LSU_INSERT, 64'h40, 64'd7, 64'h55);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req_i.lsu_op = LSU_LOAD;
                req_i.header_data.addr = 64'h10;
                req_i.val = 1'b1;
            end
            if (i == 2) req_i.val = 1'b0;
            chk($sformatf("stall%0d_valid", i), mem_req_valid_o, 1);
            chk($sformatf("stall%0d_addr", i),  mem_addr_o, 64'h40);
            chk($sformatf("stall%0d_we", i),    mem_we_o, 1);
            chk($sformatf("stall%0d_wdata", i), mem_wdata_o, 64'd7);
            step();
        end
        req_i.val = 1'b0;
        mem_req_ready_i = 1'b1;
        wait_rsp(lat, rdy);
        chk("stall_rsp", rsp_o.header_data, {64'h40, 64'd7, 64'h55});
        step();
        step();
        step();
        chk("stall_nbeats", log_addr.size() - base, 2);
        chk("stall_ready",  lsu_ready_o, 1);
        chk("stall_mem0",   mem[5'h08], 64'd7);
        chk("stall_mem1",   mem[5'h09], 64'h55);

        // Reset while a LOAD waits for its first response
        issue(LSU_LOAD, 64'h10, 64'h0, 64'h0);
        step();
        rst_i = 1'b1;
        step();
        chk("mid_rst_ready", lsu_ready_o,     0);
        chk("mid_rst_valid", mem_req_valid_o, 0);
        chk("mid_rst_we",    mem_we_o,        0);
        chk("mid_rst_addr",  mem_addr_o,      0);
        chk("mid_rst_wdata", mem_wdata_o,     0);
        chk("mid_rst_rsp",   rsp_o,           0);
        rst_i = 1'b0;
        step();
        chk("mid_rst_idle_ready", lsu_ready_o, 1);
        inj_rsp = 1'b1;
        step();
        inj_rsp = 1'b0;
        chk("stale_rsp_val",   rsp_o.val,       0);
        chk("stale_mem_valid", mem_req_valid_o, 0);
        step();
        chk("stale_rsp_val2",  rsp_o.val,   0);
        chk("stale_ready",     lsu_ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
